battle_sequencer: RTL and testbench

//  Top-level turn controller for the battle screen. Generates the 4-bit state bus consumed by player
//  (attack phase, 4'b0001) and the enemy-attack stage, and consumes their finished pulses/levels.

---
 rtl/battle_pkg.sv | 22 ++
 rtl/frame_timer.sv | 34 +++
 rtl/battle_sequencer.sv | 129 ++++++++++++
 tb/tb_battle_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared battle state encodings, counter widths and turn helper
package battle_pkg;

    localparam int FRAME_CNT_W = 16;
    localparam int TURN_W      = 8;

    typedef enum logic [3:0] {
        ST_TITLE  = 4'b0000,
        ST_PLAYER = 4'b0001,
        ST_ENEMY  = 4'b0010,
        ST_WIN    = 4'b0011,
        ST_LOSE   = 4'b0100,
        ST_GAP_P  = 4'b0101,
        ST_GAP_E  = 4'b0110
    } battle_state_e;

    function automatic logic [TURN_W-1:0] sat_inc(input logic [TURN_W-1:0] v,
                                                   input logic [TURN_W-1:0] max_v);
        return (v >= max_v) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - registered frame tick plus clearable frame counter with limit compare
module frame_timer
    import battle_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   clear_in,
    input  logic [FRAME_CNT_W-1:0] limit_in,
    output logic                   hit_out
);

    logic                   tick_q;
    logic [FRAME_CNT_W-1:0] count_q;

    // Clear has priority so a tick landing on a state change is not credited to the new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= 1'b0;
            count_q <= '0;
        end else begin
            tick_q <= (hcount_in == 11'd0) && (vcount_in == 10'd0);
            if (clear_in) begin
                count_q <= '0;
            end else if (tick_q) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign hit_out = (count_q == limit_in);

endmodule

// File: rtl/battle_sequencer.sv
// rtl/battle_sequencer.sv - battle turn controller: turns, frame gaps, HP checks, watchdog
module battle_sequencer
    import battle_pkg::*;
#(
    parameter int GAP_FRAMES     = 30,
    parameter int TIMEOUT_FRAMES = 900,
    parameter int RESULT_FRAMES  = 180,
    parameter int TURN_MAX       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        player_finished_in,
    input  logic        enemy_finished_in,
    input  logic [10:0] enemy_hp_in,
    input  logic [10:0] player_hp_in,
    output logic [3:0]  state_out,
    output logic [7:0]  turn_count_out,
    output logic        timeout_out,
    output logic        state_changed_out
);

    localparam logic [FRAME_CNT_W-1:0] GAP_LIM    = FRAME_CNT_W'(GAP_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] TIMEOUT_LIM = FRAME_CNT_W'(TIMEOUT_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] RESULT_LIM = FRAME_CNT_W'(RESULT_FRAMES);
    localparam logic [TURN_W-1:0]      TURN_LIM   = TURN_W'(TURN_MAX);

    battle_state_e          state_q, state_d;
    logic [TURN_W-1:0]      turn_q, turn_d;
    logic                   timeout_q, timeout_d;
    logic                   changed_q;
    logic                   state_change;
    logic                   hit;
    logic [FRAME_CNT_W-1:0] limit;

    always_comb begin
        case (state_q)
            ST_GAP_P, ST_GAP_E: limit = GAP_LIM;
            ST_WIN, ST_LOSE:    limit = RESULT_LIM;
            default:            limit = TIMEOUT_LIM;
        endcase
    end

    frame_timer u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .clear_in  (state_change),
        .limit_in  (limit),
        .hit_out   (hit)
    );

    // Finished levels are only looked at in their own turn state, so a stale level cannot skip a turn.
    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_TITLE: begin
                if (start_in) begin
                    state_d = ST_PLAYER;
                    turn_d  = '0;
                end
            end
            ST_PLAYER: begin
                if (player_finished_in) begin
                    state_d = ST_GAP_P;
                end else if (hit) begin
                    state_d   = ST_GAP_P;
                    timeout_d = 1'b1;
                end
            end
            ST_ENEMY: begin
                if (enemy_finished_in) begin
                    state_d = ST_GAP_E;
                end else if (hit) begin
                    state_d   = ST_GAP_E;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP_P: begin
                if (hit) begin
                    state_d = (enemy_hp_in == 11'd0) ? ST_WIN : ST_ENEMY;
                end
            end
            ST_GAP_E: begin
                if (hit) begin
                    if (player_hp_in == 11'd0) begin
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_PLAYER;
                        turn_d  = sat_inc(turn_q, TURN_LIM);
                    end
                end
            end
            ST_WIN, ST_LOSE: begin
                if (hit) begin
                    state_d = ST_TITLE;
                end
            end
            default: state_d = ST_TITLE;
        endcase
    end

    assign state_change = (state_d != state_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_TITLE;
            turn_q    <= '0;
            timeout_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            timeout_q <= timeout_d;
            changed_q <= state_change;
        end
    end

    assign state_out         = state_q;
    assign turn_count_out    = turn_q;
    assign timeout_out       = timeout_q;
    assign state_changed_out = changed_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// tb/tb_battle_sequencer.sv - self-checking bench for battle_sequencer against a frame-budget model
module tb_battle_sequencer;

    localparam int GAP  = 2;
    localparam int TMO  = 3;
    localparam int RES  = 4;
    localparam int TMAX = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        start = 1'b0;
    logic        pfin = 1'b0;
    logic        efin = 1'b0;
    logic [10:0] ehp = 11'd50;
    logic [10:0] php = 11'd50;
    logic [3:0]  state;
    logic [7:0]  turns;
    logic        to;
    logic        chg;

    int n_cmp = 0;
    int n_fail = 0;
    int n_to = 0;

    int m_st = 0;
    int m_left = 0;
    int m_turns = 0;
    bit m_to = 1'b0;
    bit m_chg = 1'b0;
    bit m_tick = 1'b0;

    always #5 clk = ~clk;

    battle_sequencer #(
        .GAP_FRAMES     (GAP),
        .TIMEOUT_FRAMES (TMO),
        .RESULT_FRAMES  (RES),
        .TURN_MAX       (TMAX)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .hcount_in          (hcount),
        .vcount_in          (vcount),
        .start_in           (start),
        .player_finished_in (pfin),
        .enemy_finished_in  (efin),
        .enemy_hp_in        (ehp),
        .player_hp_in       (php),
        .state_out          (state),
        .turn_count_out     (turns),
        .timeout_out        (to),
        .state_changed_out  (chg)
    );

    // Tiny 4x2 raster: one frame every 8 clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hcount == 11'd3) begin
                hcount = 11'd0;
                vcount = (vcount == 10'd1) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
        end
    end

    function automatic int budget(int s);
        case (s)
            5, 6:    return GAP;
            3, 4:    return RES;
            default: return TMO;
        endcase
    endfunction

    // Model: each timed state gets a frame budget on entry that frame ticks spend down.
    always @(posedge clk or negedge rst) begin : model
        int nxt;
        bit t;
        bit fire;
        if (!rst) begin
            m_st    <= 0;
            m_left  <= TMO;
            m_turns <= 0;
            m_to    <= 1'b0;
            m_chg   <= 1'b0;
            m_tick  <= 1'b0;
        end else begin
            fire = (m_left == 0);
            nxt  = m_st;
            t    = 1'b0;
            case (m_st)
                0: if (start) nxt = 1;
                1: if (pfin) nxt = 5; else if (fire) begin nxt = 5; t = 1'b1; end
                2: if (efin) nxt = 6; else if (fire) begin nxt = 6; t = 1'b1; end
                5: if (fire) nxt = (ehp == 11'd0) ? 3 : 2;
                6: if (fire) nxt = (php == 11'd0) ? 4 : 1;
                3, 4: if (fire) nxt = 0;
                default: nxt = 0;
            endcase
            m_to  <= t;
            m_chg <= (nxt != m_st);
            if (nxt != m_st) m_left <= budget(nxt);
            else if (m_tick && m_left > 0) m_left <= m_left - 1;
            if (m_st == 0 && nxt == 1) m_turns <= 0;
            else if (m_st == 6 && nxt == 1 && m_turns < TMAX) m_turns <= m_turns + 1;
            m_tick <= (hcount == 11'd0) && (vcount == 10'd0);
            m_st   <= nxt;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_state", int'(state), m_st);
        chk("model_turns", int'(turns), m_turns);
        chk("model_timeout", int'(to), int'(m_to));
        chk("model_changed", int'(chg), int'(m_chg));
        if (to) n_to++;
    end

    task automatic wait_state(input int s, input int max_cyc, input string name);
        int k;
        k = 0;
        while (int'(state) != s && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(state), s);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic player_turn();
        pfin = 1'b1;
        wait_state(5, 20, "player_to_gapp");
        pfin = 1'b0;
    endtask

    task automatic enemy_turn();
        efin = 1'b1;
        wait_state(6, 20, "enemy_to_gape");
        efin = 1'b0;
    endtask

    task automatic full_round();
        player_turn();
        wait_state(2, 40, "gapp_to_enemy");
        enemy_turn();
        wait_state(1, 40, "gape_to_player");
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL global_time_limit: sequence did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : main
        int k;
        cycles(3);
        chk("reset_state", int'(state), 0);
        chk("reset_turns", int'(turns), 0);
        rst = 1'b1;
        cycles(2);

        // Happy path with a stale player level carried into ENEMY
        start = 1'b1;
        wait_state(1, 20, "start_to_player");
        start = 1'b0;
        pfin = 1'b1;
        wait_state(5, 20, "player_to_gapp");
        wait_state(2, 40, "gapp_to_enemy");
        cycles(12);
        chk("stale_pfin_holds_enemy", int'(state), 2);
        pfin = 1'b0;
        enemy_turn();
        wait_state(1, 40, "gape_to_player");
        chk("turns_after_round", int'(turns), 1);

        // Watchdog on the player turn
        k = n_to;
        wait_state(5, 60, "watchdog_player");
        cycles(1);
        chk("timeout_pulses", n_to - k, 1);
        wait_state(2, 40, "gapp_to_enemy");
        enemy_turn();
        wait_state(1, 40, "gape_to_player");
        chk("turns_after_watchdog", int'(turns), 2);

        // Finished arriving in the very cycle the watchdog would fire
        k = 0;
        while (!(m_st == 1 && m_left == 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("reach_timeout_edge", m_left, 0);
        k = n_to;
        pfin = 1'b1;
        @(negedge clk);
        chk("fin_on_timeout_state", int'(state), 5);
        chk("fin_on_timeout_pulse", int'(to), 0);
        pfin = 1'b0;
        cycles(1);
        chk("fin_on_timeout_count", n_to - k, 0);
        wait_state(2, 40, "gapp_to_enemy");
        enemy_turn();
        wait_state(1, 40, "gape_to_player");

        // Win, with start held during the result screen
        ehp = 11'd0;
        player_turn();
        wait_state(3, 40, "gapp_to_win");
        start = 1'b1;
        cycles(12);
        chk("win_ignores_start", int'(state), 3);
        start = 1'b0;
        wait_state(0, 40, "win_to_title");
        chk("win_keeps_turns", int'(turns), 3);
        ehp = 11'd50;

        // Lose after one completed round
        start = 1'b1;
        wait_state(1, 20, "start_to_player");
        start = 1'b0;
        chk("turns_cleared_on_start", int'(turns), 0);
        full_round();
        php = 11'd0;
        player_turn();
        wait_state(2, 40, "gapp_to_enemy");
        enemy_turn();
        wait_state(4, 40, "gape_to_lose");
        chk("lose_keeps_turns", int'(turns), 1);
        php = 11'd50;
        wait_state(0, 60, "lose_to_title");

        // Asynchronous reset in the middle of a player turn
        start = 1'b1;
        wait_state(1, 20, "start_to_player");
        start = 1'b0;
        full_round();
        cycles(5);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_state", int'(state), 0);
        chk("async_reset_turns", int'(turns), 0);
        chk("async_reset_changed", int'(chg), 0);
        @(negedge clk);
        rst = 1'b1;
        k = n_to;
        cycles(10);
        chk("idle_after_reset", int'(state), 0);
        chk("no_pulse_after_reset", n_to - k, 0);

        // Turn counter saturation
        start = 1'b1;
        wait_state(1, 20, "start_to_player");
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            full_round();
        end
        chk("turns_saturated", int'(turns), 255);
        full_round();
        chk("turns_stay_saturated", int'(turns), 255);

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
